// File: rtl/dmem_pkg.sv
// Shared types and helpers for the load/store data memory.
// Holds the funct3 encoding, response metadata, lane-mask and load-extend helpers.
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic       is_load;
        logic [2:0] funct3;
        logic [1:0] off;
    } rsp_meta_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3)
            F3_B, F3_BU: m = 4'b0001 << off;
            F3_H, F3_HU: m = 4'b0011 << off;
            default:     m = 4'b1111;
        endcase
        return m;
    endfunction

    // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    r = {{24{sh[7]}}, sh[7:0]};
            F3_H:    r = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   r = {24'h0, sh[7:0]};
            F3_HU:   r = {16'h0, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane block RAM: WORDS x 4 x 8, per-lane write enable, registered read.
module dmem_bank #(
    parameter int WORDS = 512,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             i_clk,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [3:0]       i_we,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    output logic [31:0]      o_rdata
);

    logic [3:0][7:0] mem [WORDS];
    logic [31:0]     rdata_q;
    logic [31:0]     rdata_d;

    // Read is read-before-write; the LSU never issues a read and write in one cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = mem[i_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                mem[i_idx][b] <= i_wdata[8*b +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// RISC-V load/store unit in front of a byte-lane RAM.
// Fully pipelined: one request per cycle, one in-order response READ_LAT cycles later.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int BYTES    = 2048,
    parameter int READ_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    output logic        o_ready,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int ADDR_W = $clog2(BYTES);
    localparam int WORDS  = BYTES / 4;
    localparam int IDX_W  = ADDR_W - 2;

    logic        ready_q, ready_d;
    logic        accept;
    logic [1:0]  off;
    logic        f3_ok, align_ok, range_ok, req_err;
    logic [3:0]  bank_we;
    logic [31:0] bank_wdata;
    logic        bank_re;
    logic [31:0] bank_rdata;
    logic [31:0] word_final;
    rsp_meta_t   meta_q [READ_LAT];
    rsp_meta_t   meta_d [READ_LAT];
    rsp_meta_t   last;

    assign accept = i_req && ready_q;
    assign off    = i_addr[1:0];

    always_comb begin
        f3_ok    = 1'b1;
        align_ok = 1'b1;
        range_ok = (i_addr[31:ADDR_W] == '0);
        case (i_funct3)
            F3_B:    align_ok = 1'b1;
            F3_BU:   f3_ok    = !i_we;
            F3_H:    align_ok = !off[0];
            F3_HU: begin
                f3_ok    = !i_we;
                align_ok = !off[0];
            end
            F3_W:    align_ok = (off == 2'b00);
            default: f3_ok    = 1'b0;
        endcase
        req_err = !(f3_ok && align_ok && range_ok);
    end

    always_comb begin
        bank_we    = '0;
        bank_wdata = i_wdata;
        case (i_funct3)
            F3_B:    bank_wdata = {4{i_wdata[7:0]}};
            F3_H:    bank_wdata = {2{i_wdata[15:0]}};
            default: bank_wdata = i_wdata;
        endcase
        if (accept && i_we && !req_err) begin
            bank_we = lane_mask(i_funct3, off);
        end
        bank_re = accept && !i_we && !req_err;
    end

    dmem_bank #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_bank (
        .i_clk   (i_clk),
        .i_idx   (i_addr[ADDR_W-1:2]),
        .i_we    (bank_we),
        .i_wdata (bank_wdata),
        .i_re    (bank_re),
        .o_rdata (bank_rdata)
    );

    always_comb begin
        ready_d   = 1'b1;
        meta_d[0] = '{valid: accept, err: req_err, is_load: !i_we, funct3: i_funct3, off: off};
        for (int i = 1; i < READ_LAT; i++) begin
            meta_d[i] = meta_q[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_q <= 1'b0;
            for (int i = 0; i < READ_LAT; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            ready_q <= ready_d;
            for (int i = 0; i < READ_LAT; i++) begin
                meta_q[i] <= meta_d[i];
            end
        end
    end

    // The RAM output register is the first read stage; a second stage is added for READ_LAT=2.
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [31:0] word_q, word_d;
            always_comb word_d = bank_rdata;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end
            assign word_final = word_q;
        end else begin : g_lat1
            assign word_final = bank_rdata;
        end
    endgenerate

    assign last     = meta_q[READ_LAT-1];
    assign o_ready  = ready_q;
    assign o_rvalid = last.valid;
    assign o_err    = last.valid && last.err;
    assign o_rdata  = (last.valid && last.is_load && !last.err)
                    ? load_extend(word_final, last.funct3, last.off) : 32'h0;

endmodule
